// File: rtl/tick_debounce_pkg.sv
// Shared definitions for the tick-driven switch debouncer: FSM state encoding
// and the system tick period.
package tick_debounce_pkg;

    localparam logic [1:0] ST_ZERO  = 2'b00;
    localparam logic [1:0] ST_WAIT1 = 2'b01;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_WAIT0 = 2'b11;

    typedef enum logic [1:0] {
        ZERO  = ST_ZERO,
        WAIT1 = ST_WAIT1,
        ONE   = ST_ONE,
        WAIT0 = ST_WAIT0
    } state_t;

    // 100 MHz clock cycles between consecutive 5 ms tick strobes.
    localparam int unsigned TICK_5MS_CYCLES = 500000;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous pin inputs,
// asynchronously reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/tick_debounce.sv
// Debounces a raw switch using the 5 ms tick strobe; emits a registered level
// plus one-cycle rise/fall strobes when the level commits.
module tick_debounce
    import tick_debounce_pkg::*;
#(
    parameter int N_TICKS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sw_raw,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int CNT_W = $clog2(N_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TICKS - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             rise_next;
    logic             fall_next;
    logic             sw_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_raw),
        .q   (sw_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ZERO;
            cnt      <= '0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_fall  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            db_level <= level_next;
            db_rise  <= rise_next;
            db_fall  <= fall_next;
        end
    end

    // A disagreeing sample always wins over a coincident tick, and the tick
    // seen on the cycle a WAIT state is entered is never counted.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = db_level;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            ZERO: begin
                if (sw_s) begin
                    state_next = WAIT1;
                    cnt_next   = '0;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_next = ZERO;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_next = ONE;
                        cnt_next   = '0;
                        level_next = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_next = WAIT0;
                    cnt_next   = '0;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_next = ONE;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_next = ZERO;
                        cnt_next   = '0;
                        level_next = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ZERO;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tick_debounce.sv
// Self-checking bench for tick_debounce: hand-derived vector table, directed
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_tick_debounce;
    import tick_debounce_pkg::*;

    localparam int N_TICKS     = 3;
    localparam int TICK_PERIOD = 10;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic tick   = 1'b0;
    logic sw_raw = 1'b0;
    logic db_level;
    logic db_rise;
    logic db_fall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tick_debounce #(.N_TICKS(N_TICKS)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .sw_raw   (sw_raw),
        .db_level (db_level),
        .db_rise  (db_rise),
        .db_fall  (db_fall)
    );

    // Reference: level flips once N ticks have been seen while the synchronized
    // input disagrees with it, not counting the cycle the disagreement starts.
    logic m_s1, m_sws, m_level, m_rise, m_fall, m_armed;
    int   m_k;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 = 1'b0; m_sws = 1'b0; m_level = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0; m_armed = 1'b0; m_k = 0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_sws == m_level) begin
                m_armed = 1'b0;
                m_k = 0;
            end else if (!m_armed) begin
                m_armed = 1'b1;
                m_k = 0;
            end else if (tick) begin
                m_k++;
                if (m_k == N_TICKS) begin
                    m_level = ~m_level;
                    m_rise  = m_level;
                    m_fall  = ~m_level;
                    m_armed = 1'b0;
                    m_k = 0;
                end
            end
            m_sws = m_s1;
            m_s1  = sw_raw;
        end
    end

    typedef struct {
        logic       sw;
        logic       tk;
        logic [2:0] exp;
    } vec_t;

    vec_t vq[$];

    int phase = 0;
    bit tick_en = 1'b1;
    bit rand_tick = 1'b0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int tick_cnt = 0;

    task automatic add_vec(input logic sw, input logic tk, input logic [2:0] exp);
        vec_t v;
        v.sw = sw; v.tk = tk; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic apply_stimulus(input logic r, input logic sw, input logic tk);
        @(negedge clk);
        rst = r; sw_raw = sw; tick = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: level/rise/fall got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cycle(input logic r, input logic sw);
        logic tk;
        if (rand_tick) tk = ($urandom_range(0, 5) == 0);
        else           tk = tick_en && (phase == TICK_PERIOD - 1);
        phase = (phase == TICK_PERIOD - 1) ? 0 : phase + 1;
        apply_stimulus(r, sw, tk);
        if (tk) tick_cnt++;
        if (db_rise) rise_cnt++;
        if (db_fall) fall_cnt++;
        check_output("model", {db_level, db_rise, db_fall}, {m_level, m_rise, m_fall});
    endtask

    // Returns the cycle index (from the first call) of the first strobe, -1 if none.
    task automatic wait_strobe(input logic sw, input bit want_rise, output int lat);
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            cycle(1'b1, sw);
            if (lat < 0 && (want_rise ? db_rise : db_fall)) lat = n;
        end
    endtask

    initial begin
        int lat;
        int ticks_at_rise;
        bit reached;

        $display("[TB] tick period %0d cycles here (system: %0d)", TICK_PERIOD, TICK_5MS_CYCLES);

        add_vec(1,0,3'b000); add_vec(1,1,3'b000); add_vec(1,1,3'b000); add_vec(1,1,3'b000);
        add_vec(1,0,3'b000); add_vec(1,1,3'b000); add_vec(1,1,3'b110); add_vec(1,0,3'b100);
        add_vec(0,1,3'b100); add_vec(0,0,3'b100); add_vec(1,1,3'b100); add_vec(1,1,3'b100);
        add_vec(1,1,3'b100); add_vec(0,0,3'b100); add_vec(0,0,3'b100); add_vec(0,1,3'b100);
        add_vec(0,1,3'b100); add_vec(0,1,3'b100); add_vec(0,1,3'b001); add_vec(0,0,3'b000);
        add_vec(1,0,3'b000); add_vec(1,0,3'b000); add_vec(0,0,3'b000); add_vec(0,1,3'b000);
        add_vec(1,1,3'b000); add_vec(1,0,3'b000); add_vec(1,1,3'b000); add_vec(1,1,3'b000);
        add_vec(1,1,3'b000); add_vec(1,1,3'b110); add_vec(1,0,3'b100);

        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("reset_state", {db_level, db_rise, db_fall}, 3'b000);

        foreach (vq[i]) begin
            apply_stimulus(1'b1, vq[i].sw, vq[i].tk);
            check_output($sformatf("vec%0d", i), {db_level, db_rise, db_fall}, vq[i].exp);
        end

        // Reset held with the switch already pressed, then released.
        for (int n = 0; n < 5; n++) begin
            cycle(1'b0, 1'b1);
            check_output("rst_hold", {db_level, db_rise, db_fall}, 3'b000);
        end
        rise_cnt = 0; fall_cnt = 0;
        cycle(1'b1, 1'b1);
        check_output("rst_release", {db_level, db_rise, db_fall}, 3'b000);
        wait_strobe(1'b1, 1'b1, lat);
        check_range("rst_rise_latency", lat + 1, 23, 32);
        check_range("rst_rise_count", rise_cnt, 1, 1);

        // Short glitch while high.
        rise_cnt = 0; fall_cnt = 0;
        repeat (12) cycle(1'b1, 1'b0);
        repeat (30) cycle(1'b1, 1'b1);
        check_range("glitch_rise_count", rise_cnt, 0, 0);
        check_range("glitch_fall_count", fall_cnt, 0, 0);
        check_output("glitch_level", {db_level, db_rise, db_fall}, 3'b100);

        // Clean release.
        rise_cnt = 0; fall_cnt = 0;
        wait_strobe(1'b0, 1'b0, lat);
        check_range("release_fall_latency", lat, 23, 32);
        check_range("release_fall_count", fall_cnt, 1, 1);
        check_range("release_rise_count", rise_cnt, 0, 0);
        check_output("release_level", {db_level, db_rise, db_fall}, 3'b000);

        // Bouncing press, then settled high.
        rise_cnt = 0; fall_cnt = 0;
        for (int seg = 0; seg < 10; seg++)
            repeat (4) cycle(1'b1, (seg % 2) == 0);
        wait_strobe(1'b1, 1'b1, lat);
        check_range("bounce_rise_latency", lat, 23, 32);
        check_range("bounce_rise_count", rise_cnt, 1, 1);
        check_range("bounce_fall_count", fall_cnt, 0, 0);

        repeat (60) cycle(1'b1, 1'b0);
        check_output("release2_level", {db_level, db_rise, db_fall}, 3'b000);

        // Ticks stalled: pending press never commits until ticks resume.
        rise_cnt = 0;
        tick_en = 1'b0;
        repeat (100) cycle(1'b1, 1'b1);
        check_range("no_tick_rise_count", rise_cnt, 0, 0);
        check_output("no_tick_level", {db_level, db_rise, db_fall}, 3'b000);
        tick_en = 1'b1;
        repeat (40) cycle(1'b1, 1'b1);
        check_range("tick_resume_rise_count", rise_cnt, 1, 1);
        repeat (60) cycle(1'b1, 1'b0);
        check_output("release3_level", {db_level, db_rise, db_fall}, 3'b000);

        // Reset in WAIT1 after two counted ticks discards the pending press.
        rise_cnt = 0;
        reached = 1'b0;
        for (int n = 0; n < 60; n++) begin
            cycle(1'b1, 1'b1);
            if (m_k == 2) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("[TB] FAIL wait1_two_ticks: got timeout, expected 2 ticks within 60 cycles");
        end
        repeat (2) cycle(1'b0, 1'b1);
        check_range("rst_wait1_rise_count", rise_cnt, 0, 0);
        tick_cnt = 0;
        ticks_at_rise = -1;
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            cycle(1'b1, 1'b1);
            if (lat < 0 && db_rise) begin
                lat = n;
                ticks_at_rise = tick_cnt;
            end
        end
        check_range("requal_latency", lat, 23, 32);
        check_range("requal_ticks", ticks_at_rise, 3, 4);
        check_range("requal_rise_count", rise_cnt, 1, 1);

        // Randomized soak against the model.
        for (int seg = 0; seg < 120; seg++) begin
            int   len;
            logic val;
            len = $urandom_range(1, 40);
            val = logic'($urandom_range(0, 1));
            rand_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0) repeat ($urandom_range(1, 3)) cycle(1'b0, val);
            repeat (len) cycle(1'b1, val);
        end
        rand_tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
